// File: rtl/ws2812b_bit_decoder_if.sv
// Signal bundle between a WS2812B line decoder and its consumer.
// The consumer drives enable and the raw line; the decoder returns the pulse outputs.
interface ws2812b_bit_decoder_if;
  logic enable;
  logic din;
  logic bit_valid;
  logic bit_value;
  logic frame_reset;
  logic pulse_error;

  modport master (
    output enable, din,
    input  bit_valid, bit_value, frame_reset, pulse_error
  );

  modport slave (
    input  enable, din,
    output bit_valid, bit_value, frame_reset, pulse_error
  );
endinterface

// File: rtl/ws2812b_bit_decoder.sv
// WS2812B single-wire bit decoder: measures synchronized high/low times into bits, frame resets and errors.
// Optional short-pulse rejection is built when WS2812B_DECODER_GLITCH_FILTER_EN is defined.
//
// state | meaning
// IDLE  | no pulse in progress (after reset, disable or frame reset)
// HIGH  | measuring high time of a pulse
// LOW   | measuring low time after a pulse
// ERR   | high time overran; waiting for the line to fall
module ws2812b_bit_decoder #(
  parameter int THRESH_CYCLES   = 38,
  parameter int MAX_HIGH_CYCLES = 96,
  parameter int RESET_CYCLES    = 3200,
  parameter int MIN_HIGH_CYCLES = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  ws2812b_bit_decoder_if.slave  bus
);

  if (!(1 <= MIN_HIGH_CYCLES && MIN_HIGH_CYCLES < THRESH_CYCLES &&
        THRESH_CYCLES < MAX_HIGH_CYCLES && MAX_HIGH_CYCLES < RESET_CYCLES &&
        RESET_CYCLES <= 65535)) begin : g_param_check
    $error("ws2812b_bit_decoder: unsupported parameter combination");
  end

  localparam logic [15:0] THRESH_C = 16'(THRESH_CYCLES);
  localparam logic [15:0] MAX_C    = 16'(MAX_HIGH_CYCLES);
  localparam logic [15:0] RESET_C  = 16'(RESET_CYCLES);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, ERR} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt, cnt_inc;
  logic        din_m, din_s;
  logic [1:0]  sync_fill;
  logic        low_seen;
  logic        glitch;
  logic        bit_valid_nxt, bit_value_nxt, frame_reset_nxt, pulse_error_nxt;

  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

`ifdef WS2812B_DECODER_GLITCH_FILTER_EN
  assign glitch = (cnt < 16'(MIN_HIGH_CYCLES));
`else
  assign glitch = 1'b0;
`endif

  // A line that is already high when reset releases belongs to a discarded pulse,
  // so pulses are only accepted once a genuine low has been sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_m     <= 1'b0;
      din_s     <= 1'b0;
      sync_fill <= 2'b00;
      low_seen  <= 1'b0;
    end else begin
      din_m     <= bus.din;
      din_s     <= din_m;
      sync_fill <= {sync_fill[0], 1'b1};
      low_seen  <= low_seen | (sync_fill[1] & ~din_s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.bit_valid   <= 1'b0;
      bus.bit_value   <= 1'b0;
      bus.frame_reset <= 1'b0;
      bus.pulse_error <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      bus.bit_valid   <= bit_valid_nxt;
      bus.bit_value   <= bit_value_nxt;
      bus.frame_reset <= frame_reset_nxt;
      bus.pulse_error <= pulse_error_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    bit_valid_nxt   = 1'b0;
    bit_value_nxt   = 1'b0;
    frame_reset_nxt = 1'b0;
    pulse_error_nxt = 1'b0;
    if (!bus.enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (din_s && low_seen) begin
            state_nxt = HIGH;
            cnt_nxt   = 16'd1;
          end
        end
        HIGH: begin
          if (din_s) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == MAX_C) begin
              state_nxt       = ERR;
              pulse_error_nxt = 1'b1;
            end
          end else begin
            bit_valid_nxt = ~glitch;
            bit_value_nxt = ~glitch & (cnt >= THRESH_C);
            state_nxt     = LOW;
            cnt_nxt       = 16'd1;
          end
        end
        LOW: begin
          if (din_s) begin
            state_nxt = HIGH;
            cnt_nxt   = 16'd1;
          end else begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == RESET_C) begin
              state_nxt       = IDLE;
              cnt_nxt         = '0;
              frame_reset_nxt = 1'b1;
            end
          end
        end
        ERR: begin
          if (!din_s) begin
            state_nxt = LOW;
            cnt_nxt   = 16'd1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812b_bit_decoder.sv
// Scoreboard bench for ws2812b_bit_decoder: line segments are issued with their expected events queued,
// and a negedge monitor matches every DUT output pulse against the queue by kind, value and cycle.
module tb_ws2812b_bit_decoder;
  localparam int THRESH = 38;
  localparam int MAXH   = 96;
  localparam int RSTC   = 3200;
  localparam int MINH   = 8;

  localparam int K_BIT = 0;
  localparam int K_FR  = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int kind;
    int value;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ws2812b_bit_decoder_if bus ();

  ws2812b_bit_decoder #(
    .THRESH_CYCLES  (THRESH),
    .MAX_HIGH_CYCLES(MAXH),
    .RESET_CYCLES   (RSTC),
    .MIN_HIGH_CYCLES(MINH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  bit  armed = 1'b0;   // a pulse has ended since the last frame reset
  ev_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endfunction

  function automatic void expect_ev(int kind, int value, int at);
    ev_t e;
    e.kind = kind;
    e.value = value;
    e.cyc = at;
    exp_q.push_back(e);
  endfunction

  function automatic int outs();
    return {28'd0, bus.bit_valid, bus.bit_value, bus.frame_reset, bus.pulse_error};
  endfunction

  function automatic bit glitch_filtered(int n);
`ifdef WS2812B_DECODER_GLITCH_FILTER_EN
    return n < MINH;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: a line level held for n edge samples, starting just after edge p.
  // High: error if it lasts MAXH samples (reported MAXH+2 edges after the rise), otherwise a
  // bit 3 edges after the fall. Low: a frame reset once RSTC low samples follow a pulse.
  task automatic seg(input bit lvl, input int n);
    int p;
    p = cyc;
    bus.din = lvl;
    if (lvl) begin
      if (n >= MAXH) expect_ev(K_ERR, 0, p + MAXH + 2);
      else if (!glitch_filtered(n)) expect_ev(K_BIT, (n >= THRESH) ? 1 : 0, p + n + 3);
      armed = 1'b1;
    end else if (armed && n >= RSTC) begin
      expect_ev(K_FR, 0, p + RSTC + 2);
      armed = 1'b0;
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    int  act;
    int  kind;
    ev_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      check("missed_event_kind", -1, e.kind);
    end
    act = int'(bus.bit_valid) + int'(bus.frame_reset) + int'(bus.pulse_error);
    if (act != 0) begin
      check("one_pulse_output", act, 1);
      kind = bus.bit_valid ? K_BIT : (bus.frame_reset ? K_FR : K_ERR);
      if (exp_q.size() == 0) begin
        check("unexpected_output_kind", kind, -1);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", kind, e.kind);
        check("event_cycle", cyc, e.cyc);
        if (e.kind == K_BIT) check("bit_value", int'(bus.bit_value), e.value);
      end
    end
  end

  initial begin
    int n;
    int l;
    bus.enable = 1'b1;
    bus.din = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs(), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    seg(0, RSTC + 100);                   // power-up low: no frame reset
    seg(1, 25);  seg(0, 30);
    seg(1, 51);  seg(0, 30);
    seg(1, 38);  seg(0, 30);
    seg(1, 37);  seg(0, 30);
    for (int i = 0; i < 24; i++) begin
      seg(1, (i % 2) ? 51 : 25);
      seg(0, (i == 23) ? 2 * RSTC + 600 : 20);
    end
    seg(1, 120); seg(0, 30);
    seg(1, 51);  seg(0, 30);
    seg(1, 4);   seg(0, 30);
    seg(1, MAXH - 1); seg(0, 30);
    seg(1, MAXH);     seg(0, RSTC - 1);
    seg(1, THRESH - 1); seg(0, RSTC);
    seg(1, 1);   seg(0, 20);

    // Disable mid-pulse; the still-high line is a new pulse measured from re-enable.
    bus.din = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    bus.enable = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.enable = 1'b1;
    repeat (36) @(posedge clk);
    #1;
    expect_ev(K_BIT, 1, cyc + 3);
    armed = 1'b1;
    seg(0, 40);

    // Disable during a long low: no frame reset for that low period.
    seg(1, 51);
    bus.din = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    bus.enable = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    bus.enable = 1'b1;
    repeat (RSTC + 50) @(posedge clk);
    #1;
    armed = 1'b0;

    // Reset in the middle of a 51-cycle pulse.
    seg(1, 25); seg(0, 20);
    check("queue_empty_before_reset", exp_q.size(), 0);
    bus.din = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("outputs_during_reset", outs(), 0);
    armed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (18) @(posedge clk);
    #1;
    seg(0, 40);
    seg(1, 51); seg(0, 30);

    for (int i = 0; i < 30; i++) begin
      n = $urandom_range(130, 1);
      seg(1, n);
      l = ($urandom_range(7, 0) == 0) ? $urandom_range(RSTC + 3, RSTC - 3) : $urandom_range(60, 1);
      seg(0, l);
    end

    seg(1, 51);
    seg(0, 60);
    repeat (5) @(posedge clk);
    #1;
    check("queue_empty_at_end", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
